// File: rtl/mul_share_resp_pkg.sv
// Shared types for the shared-multiplier request/response protocol: request
// (mulit) and result (mulot) records, port ids, and the per-port hold-buffer step.
package mul_share_resp_pkg;

  localparam int unsigned MUL_AW  = 27;
  localparam int unsigned MUL_LAT = 2;

  typedef enum logic {
    P_DBL = 1'b0,
    P_SGL = 1'b1
  } port_e;

  typedef struct packed {
    logic              en;
    port_e             tag;
    logic [MUL_AW-1:0] req_in_1;
    logic [MUL_AW-1:0] req_in_2;
  } mulit_t;

  typedef struct packed {
    logic                vld;
    port_e               tag;
    logic [2*MUL_AW-1:0] out;
  } mulot_t;

  typedef struct packed {
    mulit_t hold;
    logic   drop;
  } hold_upd_t;

  // Next hold entry for one port. A valid hold always issues before the live
  // request, so a live request that meets a stalled hold has nowhere to go.
  function automatic hold_upd_t hold_step(mulit_t hold, mulit_t live, logic issued);
    hold_upd_t r;
    r.hold = hold;
    r.drop = 1'b0;
    if (hold.en) begin
      if (issued)       r.hold = live;
      else if (live.en) r.drop = 1'b1;
    end else if (live.en && !issued) begin
      r.hold = live;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_share_resp_pipe.sv
// LAT-stage registered unsigned multiplier; valid and port tag ride with the data,
// and data registers only load on a valid beat so the output holds its last product.
module mul_pipe
  import mul_share_resp_pkg::*;
#(
  parameter int unsigned LAT = MUL_LAT
) (
  input  logic   clk,
  input  logic   reset,
  input  mulit_t in_i,
  output mulot_t out_o
);

  mulot_t stage_q [LAT];
  logic [2*MUL_AW-1:0] prod;

  assign prod = (2*MUL_AW)'(in_i.req_in_1) * (2*MUL_AW)'(in_i.req_in_2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data registers are reset as well, because the last product
      // is visible on the port and must read as zero after reset.
      for (int s = 0; s < LAT; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0].vld <= in_i.en;
      if (in_i.en) begin
        stage_q[0].tag <= in_i.tag;
        stage_q[0].out <= prod;
      end
      for (int s = 1; s < LAT; s++) begin
        stage_q[s].vld <= stage_q[s-1].vld;
        if (stage_q[s-1].vld) begin
          stage_q[s].tag <= stage_q[s-1].tag;
          stage_q[s].out <= stage_q[s-1].out;
        end
      end
    end
  end

  assign out_o = stage_q[LAT-1];

endmodule

// File: rtl/mul_share_resp.sv
// Responder for two initiators sharing one pipelined multiplier: per-port one-deep
// hold buffer, port-0 priority with a port-1 starvation override, tagged results.
module mul_share_resp
  import mul_share_resp_pkg::*;
#(
  parameter int unsigned LAT    = MUL_LAT,
  parameter int unsigned AW     = MUL_AW,
  parameter int unsigned STARVE = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_en,
  input  logic [AW-1:0]   req0_a,
  input  logic [AW-1:0]   req0_b,
  input  logic            req1_en,
  input  logic [AW-1:0]   req1_a,
  input  logic [AW-1:0]   req1_b,
  output logic [1:0]      rdy,
  output logic [1:0]      res_vld,
  output logic [2*AW-1:0] res_out,
  output logic [1:0]      ovf
);

  localparam int unsigned SW = $clog2(STARVE + 1);

  mulit_t         hold0_q, hold1_q, live0, live1, cand0, cand1, issue;
  hold_upd_t      upd0, upd1;
  logic [SW-1:0]  starve_q, starve_d;
  logic [1:0]     ovf_q, ovf_d;
  logic           force1, issue0, issue1;
  mulot_t         pout;

  always_comb begin
    live0 = '{en: req0_en, tag: P_DBL, req_in_1: req0_a, req_in_2: req0_b};
    live1 = '{en: req1_en, tag: P_SGL, req_in_1: req1_a, req_in_2: req1_b};
    cand0 = hold0_q.en ? hold0_q : live0;
    cand1 = hold1_q.en ? hold1_q : live1;

    force1 = hold1_q.en && (starve_q >= SW'(STARVE));
    issue0 = cand0.en && !force1;
    issue1 = cand1.en && !issue0;

    issue = '0;
    if (issue0)      issue = cand0;
    else if (issue1) issue = cand1;

    upd0 = hold_step(hold0_q, live0, issue0);
    upd1 = hold_step(hold1_q, live1, issue1);

    // Count only while hold1 waits; any issue or empty hold restarts the count.
    starve_d = '0;
    if (hold1_q.en && !issue1)
      starve_d = (starve_q >= SW'(STARVE)) ? starve_q : starve_q + 1'b1;

    ovf_d = ovf_q | {upd1.drop, upd0.drop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold0_q  <= '0;
      hold1_q  <= '0;
      starve_q <= '0;
      ovf_q    <= '0;
    end else begin
      hold0_q  <= upd0.hold;
      hold1_q  <= upd1.hold;
      starve_q <= starve_d;
      ovf_q    <= ovf_d;
    end
  end

  mul_pipe #(.LAT(LAT)) u_pipe (
    .clk   (clk),
    .reset (reset),
    .in_i  (issue),
    .out_o (pout)
  );

  assign rdy     = {~hold1_q.en, ~hold0_q.en};
  assign ovf     = ovf_q;
  assign res_vld = pout.vld ? ((pout.tag == P_SGL) ? 2'b10 : 2'b01) : 2'b00;
  assign res_out = pout.out;

endmodule

// File: tb/tb_mul_share_resp.sv
// Self-checking bench for mul_share_resp: per-cycle vector tables plus hand-written
// sequences for reset mid-flight, starvation and mixed back-to-back traffic.
module tb_mul_share_resp;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_en, req1_en;
  logic [AW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    rdy, res_vld, ovf;
  logic [53:0]   res_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_share_resp #(.LAT(2), .AW(AW), .STARVE(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0_en (req0_en),
    .req0_a  (req0_a),
    .req0_b  (req0_b),
    .req1_en (req1_en),
    .req1_a  (req1_a),
    .req1_b  (req1_b),
    .rdy     (rdy),
    .res_vld (res_vld),
    .res_out (res_out),
    .ovf     (ovf)
  );

  typedef struct {
    logic          en0;
    logic [AW-1:0] a0, b0;
    logic          en1;
    logic [AW-1:0] a1, b1;
    logic [1:0]    vld;
    logic          chk_out;
    logic [53:0]   out;
    logic [1:0]    rdy;
    logic [1:0]    ovf;
  } vec_t;

  typedef struct packed {
    logic        tag;
    logic [53:0] p;
  } exp_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_en = 1'b0; req0_a = '0; req0_b = '0;
    req1_en = 1'b0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic en0, input int a0, input int b0,
                     input logic en1, input int a1, input int b1,
                     input logic [1:0] vld, input logic chk_out, input logic [53:0] out,
                     input logic [1:0] r, input logic [1:0] o);
    vec_t v;
    v.en0 = en0; v.a0 = AW'(a0); v.b0 = AW'(b0);
    v.en1 = en1; v.a1 = AW'(a1); v.b1 = AW'(b1);
    v.vld = vld; v.chk_out = chk_out; v.out = out; v.rdy = r; v.ovf = o;
    vecs.push_back(v);
  endtask

  // One row per cycle: compare the outputs of this cycle, then present its inputs.
  task automatic run_vecs(input string tname);
    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("%s[%0d].res_vld", tname, i), 64'(res_vld), 64'(vecs[i].vld));
      check($sformatf("%s[%0d].rdy", tname, i), 64'(rdy), 64'(vecs[i].rdy));
      check($sformatf("%s[%0d].ovf", tname, i), 64'(ovf), 64'(vecs[i].ovf));
      if (vecs[i].chk_out)
        check($sformatf("%s[%0d].res_out", tname, i), 64'(res_out), 64'(vecs[i].out));
      req0_en = vecs[i].en0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
      req1_en = vecs[i].en1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
      @(negedge clk);
    end
    idle_inputs();
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   p1_seen;
    exp_t q[$];
    exp_t e;
    logic [AW-1:0] ra, rb;

    // Single request at full-scale operands; first row doubles as reset-state check.
    do_reset();
    add(1, 27'h7FFFFFF, 27'h7FFFFFF, 0, 0, 0, 2'b00, 1, 54'h0,              2'b11, 2'b00);
    add(0, 0, 0,                     0, 0, 0, 2'b00, 0, 54'h0,              2'b11, 2'b00);
    add(0, 0, 0,                     0, 0, 0, 2'b01, 1, 54'h3FFFFFF0000001, 2'b11, 2'b00);
    add(0, 0, 0,                     0, 0, 0, 2'b00, 1, 54'h3FFFFFF0000001, 2'b11, 2'b00);
    run_vecs("single");

    // Collision: port 0 goes first, port 1 waits one cycle in hold.
    do_reset();
    add(1, 2, 3, 1, 4, 5, 2'b00, 1, 54'd0,  2'b11, 2'b00);
    add(0, 0, 0, 0, 0, 0, 2'b00, 0, 54'd0,  2'b01, 2'b00);
    add(0, 0, 0, 0, 0, 0, 2'b01, 1, 54'd6,  2'b11, 2'b00);
    add(0, 0, 0, 0, 0, 0, 2'b10, 1, 54'd20, 2'b11, 2'b00);
    add(0, 0, 0, 0, 0, 0, 2'b00, 1, 54'd20, 2'b11, 2'b00);
    run_vecs("collide");

    // Overflow + starvation override: port 1 issues at cycle 4, result at cycle 6.
    do_reset();
    add(1, 1, 2, 1, 10, 10, 2'b00, 0, 54'd0,   2'b11, 2'b00);
    add(1, 2, 2, 1, 11, 11, 2'b00, 0, 54'd0,   2'b01, 2'b00);
    add(1, 3, 2, 1, 12, 12, 2'b01, 1, 54'd2,   2'b01, 2'b10);
    add(1, 4, 2, 0, 0, 0,   2'b01, 1, 54'd4,   2'b01, 2'b10);
    add(1, 5, 2, 0, 0, 0,   2'b01, 1, 54'd6,   2'b01, 2'b10);
    add(1, 6, 2, 0, 0, 0,   2'b01, 1, 54'd8,   2'b10, 2'b10);
    add(0, 0, 0, 0, 0, 0,   2'b10, 1, 54'd100, 2'b10, 2'b10);
    add(0, 0, 0, 0, 0, 0,   2'b01, 1, 54'd10,  2'b11, 2'b10);
    add(0, 0, 0, 0, 0, 0,   2'b01, 1, 54'd12,  2'b11, 2'b10);
    add(0, 0, 0, 0, 0, 0,   2'b00, 1, 54'd12,  2'b11, 2'b10);
    run_vecs("ovf");

    // Reset mid-flight: 3x5 in the pipe, a port-1 hold, ovf set; all must vanish.
    req0_en = 1'b1; req0_a = 27'd3; req0_b = 27'd5;
    req1_en = 1'b1; req1_a = 27'd1; req1_b = 27'd1;
    @(negedge clk);
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    check("rst_async.rdy", 64'(rdy), 64'(2'b11));
    check("rst_async.ovf", 64'(ovf), 64'(2'b00));
    check("rst_async.res_out", 64'(res_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rst_flight[%0d].res_vld", c), 64'(res_vld), 64'(2'b00));
      check($sformatf("rst_flight[%0d].res_out", c), 64'(res_out), 64'd0);
      @(negedge clk);
    end
    check("rst_flight.rdy", 64'(rdy), 64'(2'b11));
    check("rst_flight.ovf", 64'(ovf), 64'(2'b00));

    // Starvation: port 0 every cycle, port 1 once at cycle 0 -> result at cycle 6.
    do_reset();
    p1_seen = -1;
    for (int c = 0; c < 14; c++) begin
      if (res_vld == 2'b10) begin
        p1_seen = c;
        check("starve.p1_out", 64'(res_out), 64'd63);
      end else if (res_vld == 2'b01) begin
        if (q.size() == 0) check("starve.p0_unexpected", 64'(res_out), 64'hDEAD);
        else begin
          e = q.pop_front();
          check($sformatf("starve.p0_out@%0d", c), 64'(res_out), 64'(e.p));
        end
      end
      idle_inputs();
      if (c < 6) begin
        req0_en = 1'b1; req0_a = AW'(20 + c); req0_b = 27'd3;
        q.push_back('{tag: 1'b0, p: 54'((20 + c) * 3)});
      end
      if (c == 0) begin
        req1_en = 1'b1; req1_a = 27'd7; req1_b = 27'd9;
      end
      @(negedge clk);
    end
    check("starve.p1_cycle", 64'(p1_seen), 64'd6);
    check("starve.p0_left", 64'(q.size()), 64'd0);
    q.delete();

    // Back-to-back alternating ports with random operands against a reference model.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if (res_vld != 2'b00) begin
        if (q.size() == 0) check("mixed.unexpected_vld", 64'(res_vld), 64'd0);
        else begin
          e = q.pop_front();
          check($sformatf("mixed.vld@%0d", c), 64'(res_vld), e.tag ? 64'(2'b10) : 64'(2'b01));
          check($sformatf("mixed.out@%0d", c), 64'(res_out), 64'(e.p));
        end
      end
      idle_inputs();
      if (c < 8) begin
        ra = AW'($urandom);
        rb = AW'($urandom);
        if (c % 2 == 0) begin req0_en = 1'b1; req0_a = ra; req0_b = rb; end
        else            begin req1_en = 1'b1; req1_a = ra; req1_b = rb; end
        q.push_back('{tag: 1'(c % 2), p: 54'(ra) * 54'(rb)});
      end
      @(negedge clk);
    end
    check("mixed.left", 64'(q.size()), 64'd0);
    check("mixed.ovf", 64'(ovf), 64'(2'b00));
    check("mixed.rdy", 64'(rdy), 64'(2'b11));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_resp.md
Name: mul_share_resp

Overview:
- Responder end of the shared-multiplier request protocol (mulit in, mulot out).
- Serves two independent initiators, e.g. the double-precision and single-precision FMA datapaths, with one pipelined unsigned 27x27 multiplier.
- Resolves collisions internally: per-port one-deep hold buffer, fixed priority with a starvation guard, and per-port tagged result return.
- Sits between the initiators and the physical multiplier, so initiators no longer arbitrate among themselves.

Parameters:
- LAT, 2: multiplier pipeline depth in cycles from issue to result; legal range 1..4.
- AW, 27: operand width.
- STARVE, 3: cycles a port-1 held request may wait before it overrides port-0 priority; minimum 1.

Ports:
- clk, input, 1: clock; all state on rising edge.
- reset, input, 1: asynchronous active-high reset.
- req0_en, input, 1: port-0 request strobe (mulit.en).
- req0_a, input, AW: port-0 operand 1 (mulit.req_in_1).
- req0_b, input, AW: port-0 operand 2 (mulit.req_in_2).
- req1_en, input, 1: port-1 request strobe.
- req1_a, input, AW: port-1 operand 1.
- req1_b, input, AW: port-1 operand 2.
- rdy, output, 2: rdy[i]=1 when port i's hold buffer is empty.
- res_vld, output, 2: one-hot result valid, bit i for port i.
- res_out, output, 2*AW: product (mulot.out).
- ovf, output, 2: sticky per-port dropped-request flag.

Behaviour:
- Reset, asserted asynchronously, clears:
  - hold valids, pipeline valids and tags, starvation counter;
  - outputs: res_vld=0, res_out=0, ovf=0, rdy=2'b11.
  - Any in-flight products are discarded and never returned.
- Candidate per port is that port's hold entry if valid, else its live request. This keeps per-port order: a held request always issues before a newer live one.
- Issue selection, at most one per cycle:
  - Port 1 wins if hold1 is valid and the starvation count is >= STARVE.
  - Otherwise port 0 wins if it has a candidate.
  - Otherwise port 1 wins if it has a candidate.
  - Otherwise nothing issues.
- Hold update, per port i:
  - If the hold entry issued and a live request is present, the live request loads into hold; hold stays valid.
  - If the hold entry issued and no live request is present, hold clears.
  - If hold is empty, a live request arrives and it does not issue, it loads into hold.
  - If hold is valid, did not issue, and a live request arrives, the live request is dropped and ovf[i] is set. ovf stays set until reset.
- Starvation counter:
  - Increments, saturating at STARVE, each cycle hold1 is valid and not issued.
  - Clears when hold1 issues or becomes empty.
- Pipeline:
  - The issued operands feed stage 1.
  - The product is a[AW-1:0]*b[AW-1:0] unsigned, 2*AW bits, no truncation.
  - A valid bit and a 1-bit tag (port id) travel alongside the data.
  - After LAT registered stages: res_vld = onehot(tag) when valid, and res_out = product.
  - When no result is valid: res_vld=0 and res_out holds its last value. Do not rely on res_out then.
- Latency:
  - Live request issued the same cycle: result LAT cycles later.
  - Request that waits k cycles in hold: LAT+k cycles.
- Throughput is one product per cycle. Results leave in issue order.
- Simultaneous live requests on both ports with both holds empty: port 0 issues, port 1 is held, rdy[1] drops the next cycle.
- rdy is advisory. Initiators must not present a request while rdy[i]=0 unless they accept drop semantics.

Decomposition:
- Shared package holds:
  - mulit/mulot struct typedefs, with mulit widened by a tag field;
  - MUL_AW=27 and MUL_LAT=2 constants;
  - a port-id enum (P_DBL=0, P_SGL=1).
- One natural sub-module: mul_pipe. It is a LAT-stage registered multiplier carrying valid and tag, reset asynchronously on reset.
- Arbitration, hold buffers and starvation counter stay in the top.

Test Plan:
1. Reset mid-flight: issue port0 3x5, assert reset the next cycle → no res_vld ever; res_out=0, rdy=2'b11, ovf=0.
2. Single request: cycle 0, port0 a=27'h7FFFFFF, b=27'h7FFFFFF → cycle LAT: res_vld=2'b01, res_out=54'h3FFFFFF0000001.
3. Collision: cycle 0, port0 2x3 and port1 4x5 → cycle LAT res_vld=01, out=6; cycle LAT+1 res_vld=10, out=20; rdy[1]=0 during cycle 1 only.
4. Overflow: port0 streams every cycle while port1 sends 3 requests in 3 consecutive cycles → second and third port1 requests drop, ovf=2'b10; the first port1 result returns.
5. Starvation: port0 requests every cycle, port1 one request at cycle 0 → port1 issues at cycle STARVE+1 and its result arrives at STARVE+1+LAT; port0 order is preserved.
6. Back-to-back mixed: alternate ports for 8 cycles with random operands → every product matches a reference model, tag order equals issue order, ovf=0.
